// File: rtl/logic_op_arbiter_if.sv
// =============================================================================
// logic_op_arbiter_if : request and result bundle for logic_op_arbiter
// Optional LOGIC_ARB_ERR_EN adds res_err.                         Rev 1.0
// =============================================================================
`default_nettype none

interface logic_op_arbiter_if #(
   parameter int WIDTH = 8
);
   logic [3:0]         req;
   logic [11:0]        op;
   logic [4*WIDTH-1:0] a_in;
   logic [4*WIDTH-1:0] b_in;
   logic [3:0]         grant;
   logic               res_valid;
   logic [WIDTH-1:0]   res_data;
   logic [1:0]         res_id;
   logic               res_ready;
`ifdef LOGIC_ARB_ERR_EN
   logic               res_err;
`endif

   modport slave (
      input  req, op, a_in, b_in, res_ready,
`ifdef LOGIC_ARB_ERR_EN
      output res_err,
`endif
      output grant, res_valid, res_data, res_id
   );

   modport master (
      output req, op, a_in, b_in, res_ready,
`ifdef LOGIC_ARB_ERR_EN
      input  res_err,
`endif
      input  grant, res_valid, res_data, res_id
   );
endinterface

`default_nettype wire

// File: rtl/logic_op_arbiter.sv
// =============================================================================
// logic_op_arbiter : four clients share one registered bitwise logic unit,
// round-robin grant. Optional LOGIC_ARB_ERR_EN flags opcode 7.    Rev 1.0
// =============================================================================
`default_nettype none

module logic_op_arbiter #(
   parameter int WIDTH = 8
) (
   input  wire                   clk,
   input  wire                   rst,
   logic_op_arbiter_if.slave     bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [1:0]         ptr, ptr_nxt;
   logic [3:0]         grant, grant_nxt;
   logic [2:0]         op_cap, op_cap_nxt;
   logic [WIDTH-1:0]   a_cap, a_cap_nxt;
   logic [WIDTH-1:0]   b_cap, b_cap_nxt;
   logic [1:0]         id_cap, id_cap_nxt;
   logic               res_valid, res_valid_nxt;
   logic [WIDTH-1:0]   res_data, res_data_nxt;
   logic [1:0]         res_id, res_id_nxt;
`ifdef LOGIC_ARB_ERR_EN
   logic               res_err, res_err_nxt;
`endif

   logic [1:0]         win;
   logic               win_found;
   logic [1:0]         cand;
   logic [2:0]         op_sel;
   logic [WIDTH-1:0]   a_sel;
   logic [WIDTH-1:0]   b_sel;

   function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] code,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      case (code)
         3'd0:    logic_op = a & b;
         3'd1:    logic_op = a | b;
         3'd2:    logic_op = ~a;
         3'd3:    logic_op = ~(a & b);
         3'd4:    logic_op = ~(a | b);
         3'd5:    logic_op = a ^ b;
         3'd6:    logic_op = ~(a ^ b);
         default: logic_op = '0;
      endcase
   endfunction

   // First requester at or after ptr, wrapping 3 -> 0.
   always_comb begin
      win       = ptr;
      win_found = 1'b0;
      cand      = '0;
      for (int i = 0; i < 4; i++) begin
         cand = ptr + 2'(i);
         if (!win_found && bus.req[cand]) begin
            win       = cand;
            win_found = 1'b1;
         end
      end
   end

   always_comb begin
      op_sel = '0;
      a_sel  = '0;
      b_sel  = '0;
      for (int i = 0; i < 4; i++) begin
         if (win == 2'(i)) begin
            op_sel = bus.op[3*i +: 3];
            a_sel  = bus.a_in[WIDTH*i +: WIDTH];
            b_sel  = bus.b_in[WIDTH*i +: WIDTH];
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      ptr_nxt       = ptr;
      grant_nxt     = '0;
      op_cap_nxt    = op_cap;
      a_cap_nxt     = a_cap;
      b_cap_nxt     = b_cap;
      id_cap_nxt    = id_cap;
      res_valid_nxt = res_valid;
      res_data_nxt  = res_data;
      res_id_nxt    = res_id;
`ifdef LOGIC_ARB_ERR_EN
      res_err_nxt   = res_err;
`endif
      case (state)
         IDLE: begin
            if (win_found) begin
               grant_nxt  = 4'b0001 << win;
               op_cap_nxt = op_sel;
               a_cap_nxt  = a_sel;
               b_cap_nxt  = b_sel;
               id_cap_nxt = win;
               state_nxt  = EXEC;
            end
         end
         EXEC: begin
            res_data_nxt  = logic_op(op_cap, a_cap, b_cap);
            res_id_nxt    = id_cap;
            res_valid_nxt = 1'b1;
`ifdef LOGIC_ARB_ERR_EN
            res_err_nxt   = (op_cap == 3'd7);
`endif
            state_nxt     = RESP;
         end
         RESP: begin
            if (bus.res_ready) begin
               res_valid_nxt = 1'b0;
`ifdef LOGIC_ARB_ERR_EN
               res_err_nxt   = 1'b0;
`endif
               ptr_nxt       = res_id + 2'd1;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         grant     <= '0;
         op_cap    <= '0;
         a_cap     <= '0;
         b_cap     <= '0;
         id_cap    <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= '0;
`ifdef LOGIC_ARB_ERR_EN
         res_err   <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         grant     <= grant_nxt;
         op_cap    <= op_cap_nxt;
         a_cap     <= a_cap_nxt;
         b_cap     <= b_cap_nxt;
         id_cap    <= id_cap_nxt;
         res_valid <= res_valid_nxt;
         res_data  <= res_data_nxt;
         res_id    <= res_id_nxt;
`ifdef LOGIC_ARB_ERR_EN
         res_err   <= res_err_nxt;
`endif
      end
   end

   assign bus.grant     = grant;
   assign bus.res_valid = res_valid;
   assign bus.res_data  = res_data;
   assign bus.res_id    = res_id;
`ifdef LOGIC_ARB_ERR_EN
   assign bus.res_err   = res_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_logic_op_arbiter.sv
// =============================================================================
// tb_logic_op_arbiter : directed self-checking bench for logic_op_arbiter
// Checks res_err as well when LOGIC_ARB_ERR_EN is defined.        Rev 1.0
// =============================================================================
`default_nettype none

module tb_logic_op_arbiter;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;

   logic_op_arbiter_if #(.WIDTH(8)) bus ();

   logic_op_arbiter #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [7:0] sweep_exp [7];
   logic [3:0] rr_exp    [5];

   initial begin
      n_assert      = 0;
      n_fail        = 0;
      sweep_exp     = '{8'h30, 8'hFC, 8'h0F, 8'hCF, 8'h03, 8'hCC, 8'h33};
      rr_exp        = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rst           = 1'b1;
      bus.req       = '0;
      bus.op        = '0;
      bus.a_in      = '0;
      bus.b_in      = '0;
      bus.res_ready = 1'b1;
      tick();
      tick();
      check("reset_grant",     32'(bus.grant),     32'h0);
      check("reset_res_valid", 32'(bus.res_valid), 32'h0);
      check("reset_res_data",  32'(bus.res_data),  32'h0);
      check("reset_res_id",    32'(bus.res_id),    32'h0);
`ifdef LOGIC_ARB_ERR_EN
      check("reset_res_err",   32'(bus.res_err),   32'h0);
`endif
      rst = 1'b0;
      tick();

      // Client 1 opcode sweep with a=F0, b=3C.
      bus.a_in[15:8] = 8'hF0;
      bus.b_in[15:8] = 8'h3C;
      for (int k = 0; k < 7; k++) begin
         bus.op[5:3] = 3'(k);
         bus.req     = 4'b0010;
         tick();
         check("sweep_grant",     32'(bus.grant),     32'h2);
         check("sweep_early_vld", 32'(bus.res_valid), 32'h0);
         bus.req = '0;
         tick();
         check("sweep_res_valid", 32'(bus.res_valid), 32'h1);
         check("sweep_res_data",  32'(bus.res_data),  32'(sweep_exp[k]));
         check("sweep_res_id",    32'(bus.res_id),    32'h1);
         tick();
         check("sweep_handshake", 32'(bus.res_valid), 32'h0);
      end

      // Reset while a result is pending in RESP.
      bus.res_ready   = 1'b0;
      bus.a_in[23:16] = 8'h0F;
      bus.b_in[23:16] = 8'hFF;
      bus.req         = 4'b0100;
      tick();
      check("pre_rst_grant", 32'(bus.grant), 32'h4);
      bus.req = '0;
      tick();
      check("pre_rst_valid", 32'(bus.res_valid), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(bus.res_valid), 32'h0);
      check("async_rst_grant", 32'(bus.grant),     32'h0);
      check("async_rst_data",  32'(bus.res_data),  32'h0);
      tick();
      rst           = 1'b0;
      bus.res_ready = 1'b1;
      bus.req       = 4'b1111;

      // Round-robin fairness starting from ptr=0.
      for (int g = 0; g < 5; g++) begin
         tick();
         check("rr_grant", 32'(bus.grant), 32'(rr_exp[g]));
         if (g == 4) bus.req = '0;
         tick();
         check("rr_grant_pulse", 32'(bus.grant),  32'h0);
         check("rr_res_id",      32'(bus.res_id), 32'((g == 4) ? 0 : g));
         tick();
         check("rr_gap_grant", 32'(bus.grant), 32'h0);
      end

      // Backpressure: client 3 XOR while client 0 waits.
      bus.op[11:9]    = 3'd5;
      bus.a_in[31:24] = 8'h12;
      bus.b_in[31:24] = 8'h34;
      bus.res_ready   = 1'b0;
      bus.req         = 4'b1001;
      tick();
      check("bp_grant", 32'(bus.grant), 32'h8);
      tick();
      check("bp_res_data", 32'(bus.res_data), 32'h26);
      check("bp_res_id",   32'(bus.res_id),   32'h3);
      bus.a_in[31:24] = 8'hFF;
      for (int s = 0; s < 5; s++) begin
         tick();
         check("bp_stall_valid", 32'(bus.res_valid), 32'h1);
         check("bp_stall_data",  32'(bus.res_data),  32'h26);
         check("bp_stall_id",    32'(bus.res_id),    32'h3);
         check("bp_stall_grant", 32'(bus.grant),     32'h0);
      end
      bus.res_ready = 1'b1;
      tick();
      check("bp_handshake", 32'(bus.res_valid), 32'h0);
      check("bp_hs_grant",  32'(bus.grant),     32'h0);
      tick();
      check("bp_next_grant", 32'(bus.grant), 32'h1);
      bus.req = '0;
      tick();
      check("bp_next_id", 32'(bus.res_id), 32'h0);
      tick();

      // Operand isolation on client 2.
      bus.op[8:6]     = 3'd0;
      bus.a_in[23:16] = 8'hAA;
      bus.b_in[23:16] = 8'hFF;
      bus.req         = 4'b0100;
      tick();
      check("iso_grant", 32'(bus.grant), 32'h4);
      bus.a_in[23:16] = 8'h55;
      bus.req         = '0;
      tick();
      check("iso_res_data", 32'(bus.res_data), 32'hAA);
      check("iso_res_id",   32'(bus.res_id),   32'h2);
      tick();

      // Illegal opcode.
      bus.op[8:6]     = 3'd7;
      bus.a_in[23:16] = 8'hFF;
      bus.b_in[23:16] = 8'hFF;
      bus.req         = 4'b0100;
      tick();
      check("ill_grant", 32'(bus.grant), 32'h4);
      bus.req       = '0;
      bus.res_ready = 1'b0;
      tick();
      check("ill_res_valid", 32'(bus.res_valid), 32'h1);
      check("ill_res_data",  32'(bus.res_data),  32'h0);
`ifdef LOGIC_ARB_ERR_EN
      check("ill_res_err",   32'(bus.res_err),   32'h1);
`endif
      tick();
`ifdef LOGIC_ARB_ERR_EN
      check("ill_err_hold",  32'(bus.res_err),   32'h1);
`endif
      check("ill_valid_hold", 32'(bus.res_valid), 32'h1);
      bus.res_ready = 1'b1;
      tick();
      check("ill_handshake", 32'(bus.res_valid), 32'h0);
`ifdef LOGIC_ARB_ERR_EN
      check("ill_err_clear", 32'(bus.res_err),   32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
